// File: rtl/serial_word_shifter_if.sv
// Word-input handshake between a producer and the serial word shifter.
interface serial_word_shifter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial front end for the Mealy zero detector: WIDTH-bit words
// in over valid/ready, one bit per clock out on x_out, with a one-word
// holding register so consecutive words stream with no idle gap.
module serial_word_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_word_shifter_if.slave s_in,
  output logic                 x_out,
  output logic                 x_valid,
  output logic                 x_last,
  output logic                 busy
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_sh, w_sh_next;
  logic [WIDTH-1:0] r_hold, w_hold_next;
  logic             r_hold_full, w_hold_full_next;
  logic             r_x_out, r_x_valid, r_x_last, r_busy;
  logic             w_accept, w_at_last, w_head_next;
  logic [WIDTH-1:0] w_sh_shifted;

  assign w_accept  = s_in.din_valid & ~r_hold_full;
  assign w_at_last = (r_state == SHIFT) && (r_cnt == LAST_CNT);
  assign w_sh_shifted = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_sh[WIDTH-1:1]};

  // Next-state logic: word routing, bit advance, hold-to-shifter transfer.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_sh_next        = r_sh;
    w_hold_next      = r_hold;
    w_hold_full_next = r_hold_full;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = SHIFT;
          w_sh_next    = s_in.din;
          w_cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (w_at_last) begin
          // Held word has priority; acceptance is blocked while it is full,
          // so the two load sources never collide.
          if (r_hold_full) begin
            w_sh_next        = r_hold;
            w_hold_full_next = 1'b0;
            w_cnt_next       = '0;
          end else if (w_accept) begin
            w_sh_next  = s_in.din;
            w_cnt_next = '0;
          end else begin
            w_state_next = IDLE;
            w_sh_next    = '0;
            w_cnt_next   = '0;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          w_sh_next  = w_sh_shifted;
          if (w_accept) begin
            w_hold_next      = s_in.din;
            w_hold_full_next = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_head_next = MSB_FIRST ? w_sh_next[WIDTH-1] : w_sh_next[0];

  // Engine and holding-register state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_sh        <= w_sh_next;
      r_hold      <= w_hold_next;
      r_hold_full <= w_hold_full_next;
    end
  end

  // Registered outputs, computed from next state so they align with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x_out   <= 1'b0;
      r_x_valid <= 1'b0;
      r_x_last  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_x_out   <= (w_state_next == SHIFT) & w_head_next;
      r_x_valid <= (w_state_next == SHIFT);
      r_x_last  <= (w_state_next == SHIFT) && (w_cnt_next == LAST_CNT);
      r_busy    <= (w_state_next == SHIFT) | w_hold_full_next;
    end
  end

  assign s_in.din_ready = ~r_hold_full;
  assign x_out   = r_x_out;
  assign x_valid = r_x_valid;
  assign x_last  = r_x_last;
  assign busy    = r_busy;

endmodule
